// File: rtl/rx_pwr_seq.sv
// Receiver power-up / calibration sequencer.
// Walks N_BLK analog sub-blocks through power-up, settle, calibrate and
// ready, either all together (parallel) or one after another in index
// order (sequential). Reports calibration timeouts and loss of ready.
//
// Per-block handshake: PU_BLK[i] powers block i and stays high until the
// receiver is disabled. CAL_BLK[i] is a request that the controller holds
// high until it samples RDY_BLK[i]=1 on a rising CLK edge; CAL_BLK[i] drops
// on that same edge. RDY_BLK[i] is ignored while CAL_BLK[i] is low, except
// in DONE, where every RDY_BLK bit must stay high.
module rx_pwr_seq #(
    parameter int N_BLK      = 3,
    parameter int SETTLE_CYC = 4,
    parameter int TMO_CYC    = 200,
    parameter int CNT_W      = 8,
    parameter int IDX_W      = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             PU_RX,
    input  logic             SEQ_MODE,
    input  logic [N_BLK-1:0] RDY_BLK,
    output logic [N_BLK-1:0] PU_BLK,
    output logic [N_BLK-1:0] CAL_BLK,
    output logic             RDY_RX,
    output logic             ERR_RX,
    output logic [IDX_W-1:0] ERR_IDX,
    output logic             BUSY,
    output logic [2:0]       DBG_STATE
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_CAL    = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    localparam logic [N_BLK-1:0] P_LSB = N_BLK'(1);
    localparam logic [N_BLK-1:0] P_ALL = '1;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic             r_seq, w_seq_nxt;
    logic [N_BLK-1:0] r_ack, w_ack_nxt;
    logic [N_BLK-1:0] r_pu, w_pu_nxt;
    logic [N_BLK-1:0] r_cal, w_cal_nxt;
    logic             r_rdy, w_rdy_nxt;
    logic             r_err, w_err_nxt;
    logic [IDX_W-1:0] r_err_idx, w_err_idx_nxt;
    logic             r_busy;

    logic [N_BLK-1:0] w_hit;
    logic [N_BLK-1:0] w_ack_all;
    logic [N_BLK-1:0] w_idx_mask;
    logic [IDX_W-1:0] w_idx_inc;
    logic             w_idx_hit;
    logic             w_last;
    logic             w_settle_done;
    logic             w_cal_done;
    logic             w_seq_adv;
    logic             w_tmo;
    logic             w_rdy_lost;

    // Lowest index whose bit is set in v (0 if none).
    function automatic logic [IDX_W-1:0] f_first_one(input logic [N_BLK-1:0] v);
        f_first_one = '0;
        for (int i = N_BLK - 1; i >= 0; i--) begin
            if (v[i]) f_first_one = IDX_W'(i);
        end
    endfunction

    // Decode of the current block handshakes and counter thresholds.
    always_comb begin
        w_hit         = RDY_BLK & r_cal;
        w_ack_all     = r_ack | w_hit;
        w_idx_mask    = P_LSB << r_idx;
        w_idx_inc     = r_idx + IDX_W'(1);
        w_idx_hit     = |(w_hit & w_idx_mask);
        w_last        = (r_idx == IDX_W'(N_BLK - 1));
        w_settle_done = (r_cnt == CNT_W'(SETTLE_CYC - 1));
        w_cal_done    = r_seq ? (w_idx_hit && w_last) : (&w_ack_all);
        w_seq_adv     = r_seq && w_idx_hit && !w_last;
        // Fires on the edge where the CAL counter would reach TMO_CYC-1.
        w_tmo         = (r_cnt == CNT_W'(TMO_CYC - 2));
        w_rdy_lost    = ~&RDY_BLK;
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; receiver disable overrides every other event.
    always_comb begin
        w_state_nxt = r_state;
        if (!PU_RX) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   w_state_nxt = S_SETTLE;
                S_SETTLE: if (w_settle_done) w_state_nxt = S_CAL;
                S_CAL: begin
                    if (w_cal_done)     w_state_nxt = S_DONE;
                    else if (w_seq_adv) w_state_nxt = S_SETTLE;
                    else if (w_tmo)     w_state_nxt = S_ERR;
                end
                S_DONE:   if (w_rdy_lost) w_state_nxt = S_ERR;
                S_ERR:    w_state_nxt = S_ERR;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Next values of the datapath and of every registered output.
    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_seq_nxt     = r_seq;
        w_ack_nxt     = r_ack;
        w_pu_nxt      = r_pu;
        w_cal_nxt     = r_cal;
        w_rdy_nxt     = r_rdy;
        w_err_nxt     = r_err;
        w_err_idx_nxt = r_err_idx;
        if (!PU_RX) begin
            w_cnt_nxt     = '0;
            w_idx_nxt     = '0;
            w_seq_nxt     = 1'b0;
            w_ack_nxt     = '0;
            w_pu_nxt      = '0;
            w_cal_nxt     = '0;
            w_rdy_nxt     = 1'b0;
            w_err_nxt     = 1'b0;
            w_err_idx_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_seq_nxt     = SEQ_MODE;
                    w_cnt_nxt     = '0;
                    w_idx_nxt     = '0;
                    w_ack_nxt     = '0;
                    w_cal_nxt     = '0;
                    w_rdy_nxt     = 1'b0;
                    w_err_nxt     = 1'b0;
                    w_err_idx_nxt = '0;
                    w_pu_nxt      = SEQ_MODE ? P_LSB : P_ALL;
                end
                S_SETTLE: begin
                    if (w_settle_done) begin
                        w_cnt_nxt = '0;
                        w_cal_nxt = r_seq ? w_idx_mask : P_ALL;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_CAL: begin
                    w_cal_nxt = r_cal & ~w_hit;
                    w_ack_nxt = w_ack_all;
                    if (w_cal_done) begin
                        w_rdy_nxt = 1'b1;
                        w_cal_nxt = '0;
                        w_pu_nxt  = P_ALL;
                        w_cnt_nxt = '0;
                    end else if (w_seq_adv) begin
                        w_idx_nxt = w_idx_inc;
                        w_pu_nxt  = r_pu | (P_LSB << w_idx_inc);
                        w_cnt_nxt = '0;
                    end else if (w_tmo) begin
                        w_err_nxt     = 1'b1;
                        w_cal_nxt     = '0;
                        w_err_idx_nxt = r_seq ? r_idx : f_first_one(~w_ack_all);
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (w_rdy_lost) begin
                        w_rdy_nxt     = 1'b0;
                        w_err_nxt     = 1'b1;
                        w_err_idx_nxt = f_first_one(~RDY_BLK);
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_seq     <= 1'b0;
            r_ack     <= '0;
            r_pu      <= '0;
            r_cal     <= '0;
            r_rdy     <= 1'b0;
            r_err     <= 1'b0;
            r_err_idx <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_seq     <= w_seq_nxt;
            r_ack     <= w_ack_nxt;
            r_pu      <= w_pu_nxt;
            r_cal     <= w_cal_nxt;
            r_rdy     <= w_rdy_nxt;
            r_err     <= w_err_nxt;
            r_err_idx <= w_err_idx_nxt;
            r_busy    <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_CAL);
        end
    end

    // Output mapping.
    always_comb begin
        PU_BLK    = r_pu;
        CAL_BLK   = r_cal;
        RDY_RX    = r_rdy;
        ERR_RX    = r_err;
        ERR_IDX   = r_err_idx;
        BUSY      = r_busy;
        DBG_STATE = r_state;
    end

endmodule

// File: tb/tb_rx_pwr_seq.sv
// Directed bench for rx_pwr_seq (N_BLK=3, SETTLE_CYC=4, TMO_CYC=16).
module tb_rx_pwr_seq;

    logic       clk;
    logic       rst_n;
    logic       pu_rx;
    logic       seq_mode;
    logic [2:0] rdy_blk;
    logic [2:0] pu_blk;
    logic [2:0] cal_blk;
    logic       rdy_rx;
    logic       err_rx;
    logic [1:0] err_idx;
    logic       busy;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;

    rx_pwr_seq #(
        .N_BLK(3), .SETTLE_CYC(4), .TMO_CYC(16), .CNT_W(8), .IDX_W(2)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .PU_RX(pu_rx), .SEQ_MODE(seq_mode),
        .RDY_BLK(rdy_blk), .PU_BLK(pu_blk), .CAL_BLK(cal_blk),
        .RDY_RX(rdy_rx), .ERR_RX(err_rx), .ERR_IDX(err_idx),
        .BUSY(busy), .DBG_STATE(dbg_state)
    );

    // Clock / reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       pu;
        logic       seq;
        logic [2:0] rdy;
        logic [2:0] e_pu;
        logic [2:0] e_cal;
        logic       e_rdy;
        logic       e_err;
        logic [1:0] e_idx;
        logic       e_busy;
    } vec_t;

    vec_t vec_q[$];

    task automatic add(input int n, input logic pu, input logic seq, input logic [2:0] rdy,
                       input logic [2:0] e_pu, input logic [2:0] e_cal, input logic e_rdy,
                       input logic e_err, input logic [1:0] e_idx, input logic e_busy);
        vec_t v;
        v.pu = pu; v.seq = seq; v.rdy = rdy;
        v.e_pu = e_pu; v.e_cal = e_cal; v.e_rdy = e_rdy;
        v.e_err = e_err; v.e_idx = e_idx; v.e_busy = e_busy;
        for (int i = 0; i < n; i++) vec_q.push_back(v);
    endtask

    task automatic check_out(input string tag, input int n,
                             input logic [2:0] e_pu, input logic [2:0] e_cal, input logic e_rdy,
                             input logic e_err, input logic [1:0] e_idx, input logic e_busy);
        checks++;
        if (pu_blk !== e_pu || cal_blk !== e_cal || rdy_rx !== e_rdy ||
            err_rx !== e_err || err_idx !== e_idx || busy !== e_busy) begin
            errors++;
            $display("FAIL %s[%0d] got pu=%b cal=%b rdy=%b err=%b idx=%0d busy=%b exp pu=%b cal=%b rdy=%b err=%b idx=%0d busy=%b",
                     tag, n, pu_blk, cal_blk, rdy_rx, err_rx, err_idx, busy,
                     e_pu, e_cal, e_rdy, e_err, e_idx, e_busy);
        end
    endtask

    task automatic check_state(input string tag, input logic [2:0] e_state);
        checks++;
        if (dbg_state !== e_state) begin
            errors++;
            $display("FAIL %s got state=%0d exp state=%0d", tag, dbg_state, e_state);
        end
    endtask

    // One rising edge, then settle #1 before any sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pu, input logic seq, input logic [2:0] rdy);
        pu_rx = pu; seq_mode = seq; rdy_blk = rdy;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 3'b000);
        step();
        step();
        check_out("reset", 0, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0);
        check_state("reset_state", 3'd0);
        #2 rst_n = 1'b1;
        step();
        check_out("idle", 0, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0);

        // Parallel nominal, then ready-loss, then disable.
        add(4, 1, 0, 3'b000, 3'b111, 3'b000, 0, 0, 2'd0, 1);
        add(2, 1, 0, 3'b000, 3'b111, 3'b111, 0, 0, 2'd0, 1);
        add(2, 1, 0, 3'b001, 3'b111, 3'b110, 0, 0, 2'd0, 1);
        add(1, 1, 0, 3'b011, 3'b111, 3'b100, 0, 0, 2'd0, 1);
        add(2, 1, 0, 3'b111, 3'b111, 3'b000, 1, 0, 2'd0, 0);
        add(1, 1, 0, 3'b011, 3'b111, 3'b000, 0, 1, 2'd2, 0);
        add(2, 1, 0, 3'b111, 3'b111, 3'b000, 0, 1, 2'd2, 0);
        add(2, 0, 0, 3'b111, 3'b000, 3'b000, 0, 0, 2'd0, 0);
        // Sequential nominal; SEQ_MODE dropped mid-run must be ignored.
        add(4, 1, 1, 3'b000, 3'b001, 3'b000, 0, 0, 2'd0, 1);
        add(2, 1, 1, 3'b000, 3'b001, 3'b001, 0, 0, 2'd0, 1);
        add(1, 1, 1, 3'b001, 3'b011, 3'b000, 0, 0, 2'd0, 1);
        add(3, 1, 0, 3'b001, 3'b011, 3'b000, 0, 0, 2'd0, 1);
        add(2, 1, 0, 3'b001, 3'b011, 3'b010, 0, 0, 2'd0, 1);
        add(1, 1, 0, 3'b011, 3'b111, 3'b000, 0, 0, 2'd0, 1);
        add(3, 1, 0, 3'b011, 3'b111, 3'b000, 0, 0, 2'd0, 1);
        add(2, 1, 0, 3'b011, 3'b111, 3'b100, 0, 0, 2'd0, 1);
        add(1, 1, 0, 3'b111, 3'b111, 3'b000, 1, 0, 2'd0, 0);
        add(1, 0, 0, 3'b111, 3'b000, 3'b000, 0, 0, 2'd0, 0);
        // Parallel timeout on block 1: error at t0+19.
        add(4, 1, 0, 3'b000, 3'b111, 3'b000, 0, 0, 2'd0, 1);
        add(2, 1, 0, 3'b000, 3'b111, 3'b111, 0, 0, 2'd0, 1);
        add(13, 1, 0, 3'b101, 3'b111, 3'b010, 0, 0, 2'd0, 1);
        add(2, 1, 0, 3'b101, 3'b111, 3'b000, 0, 1, 2'd1, 0);
        add(1, 0, 0, 3'b000, 3'b000, 3'b000, 0, 0, 2'd0, 0);

        for (int i = 0; i < vec_q.size(); i++) begin
            drive(vec_q[i].pu, vec_q[i].seq, vec_q[i].rdy);
            step();
            check_out("vec", i, vec_q[i].e_pu, vec_q[i].e_cal, vec_q[i].e_rdy,
                      vec_q[i].e_err, vec_q[i].e_idx, vec_q[i].e_busy);
        end

        // RDY on the timeout edge is accepted.
        drive(1'b1, 1'b0, 3'b000);
        for (int k = 0; k <= 18; k++) begin
            if (k == 6) rdy_blk = 3'b101;
            step();
        end
        check_out("tmo_edge_pre", 18, 3'b111, 3'b010, 0, 0, 2'd0, 1);
        rdy_blk = 3'b111;
        step();
        check_out("tmo_edge_rdy", 19, 3'b111, 3'b000, 1, 0, 2'd0, 0);
        drive(1'b0, 1'b0, 3'b000);
        step();

        // Abort during sequential CAL of block 1.
        drive(1'b1, 1'b1, 3'b000);
        for (int k = 0; k <= 10; k++) begin
            if (k == 6) rdy_blk = 3'b001;
            step();
        end
        check_out("abort_pre", 10, 3'b011, 3'b010, 0, 0, 2'd0, 1);
        pu_rx = 1'b0;
        step();
        check_out("abort", 11, 3'b000, 3'b000, 0, 0, 2'd0, 0);
        check_state("abort_state", 3'd0);

        // Priority: disable on the same edge as the final RDY.
        drive(1'b1, 1'b0, 3'b000);
        for (int k = 0; k <= 5; k++) begin
            if (k == 5) rdy_blk = 3'b011;
            step();
        end
        check_out("prio_pre", 5, 3'b111, 3'b100, 0, 0, 2'd0, 1);
        drive(1'b0, 1'b0, 3'b111);
        step();
        check_out("prio", 6, 3'b000, 3'b000, 0, 0, 2'd0, 0);
        step();
        check_out("prio_hold", 7, 3'b000, 3'b000, 0, 0, 2'd0, 0);

        // Asynchronous reset between edges while in DONE.
        drive(1'b1, 1'b0, 3'b111);
        for (int k = 0; k <= 5; k++) step();
        check_out("async_pre", 5, 3'b111, 3'b000, 1, 0, 2'd0, 0);
        #3 rst_n = 1'b0;
        #1;
        check_out("async_rst", 0, 3'b000, 3'b000, 0, 0, 2'd0, 0);
        check_state("async_state", 3'd0);
        pu_rx = 1'b0;
        #2 rst_n = 1'b1;
        step();
        check_out("async_after", 1, 3'b000, 3'b000, 0, 0, 2'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_pwr_seq.md
Name: rx_pwr_seq

Overview:
- Parametrised receiver power-up/calibration sequencer; successor to the fixed three-block receiver controller.
- Drives N_BLK analog sub-blocks (IREF, SYNT, BPF, LNA, ...) through a per-block PU/CAL/RDY handshake.
- Two modes: parallel (all blocks together) and sequential (index order 0..N_BLK-1).
- Adds settle delay, calibration timeout, error reporting and loss-of-ready detection; sits between the top-level RX enable and the analog block wrappers.

Parameters:
- N_BLK, 3, number of controlled sub-blocks (1..16).
- SETTLE_CYC, 4, CLK cycles between a block's PU rising and its CAL rising (>=1).
- TMO_CYC, 200, max CLK cycles from CAL rising to RDY seen (>=2).
- CNT_W, 8, width of the shared settle/timeout counter; must hold max(SETTLE_CYC, TMO_CYC).
- IDX_W, 2, width of ERR_IDX; must satisfy 2^IDX_W >= N_BLK.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- PU_RX  in  1  receiver enable; level.
- SEQ_MODE  in  1  0 = parallel, 1 = sequential; sampled only on IDLE->SETTLE.
- RDY_BLK  in  N_BLK  per-block ready from the sub-blocks.
- PU_BLK  out  N_BLK  per-block power-up.
- CAL_BLK  out  N_BLK  per-block calibrate request.
- RDY_RX  out  1  all blocks powered and calibrated.
- ERR_RX  out  1  timeout or ready-loss error, sticky until PU_RX low.
- ERR_IDX  out  IDX_W  index of the failing block; valid while ERR_RX=1.
- BUSY  out  1  high in SETTLE or CAL.

Behaviour:
- Reset (RST_N=0, async): state IDLE; PU_BLK=0, CAL_BLK=0, RDY_RX=0, ERR_RX=0, ERR_IDX=0, BUSY=0; counter, block index and ack register cleared.
- All outputs are registered. Every transition below occurs on a rising CLK edge.
- PU_RX=0 sampled in any state: go to IDLE on that edge and clear all outputs as in reset. This has priority over every other event, including a same-cycle RDY, timeout or error.
- IDLE:
  - PU_RX=1 -> SETTLE, latch SEQ_MODE, counter=0.
  - Parallel: PU_BLK all ones.
  - Sequential: idx=0, PU_BLK[0]=1.
- SETTLE:
  - Counter increments each cycle.
  - At count SETTLE_CYC-1 -> CAL, counter=0. Net effect: CAL rises exactly SETTLE_CYC edges after the corresponding PU.
  - Parallel: CAL_BLK all ones. Sequential: CAL_BLK[idx]=1.
- CAL:
  - RDY_BLK is honoured only for blocks with CAL_BLK high. When RDY_BLK[i]=1 is sampled, CAL_BLK[i] falls on that edge and ack[i] is set.
  - Parallel: when all ack bits are set -> DONE, RDY_RX=1 on the same edge.
  - Sequential, RDY on block idx with idx<N_BLK-1: idx++, set PU_BLK[idx+1] (earlier PU bits stay high), return to SETTLE with counter=0.
  - Sequential, RDY on block idx=N_BLK-1: -> DONE, RDY_RX=1.
  - Timeout: counter reaches TMO_CYC-1 with a required ack still missing -> ERR on that edge. ERR_RX=1; ERR_IDX = lowest un-acked index (parallel) or idx (sequential); CAL_BLK all zero; PU_BLK held.
  - RDY arriving on the same edge as the timeout is accepted; the timeout does not fire.
- DONE:
  - RDY_RX=1; PU_BLK all ones; CAL_BLK zero.
  - Any RDY_BLK[i]=0 sampled -> ERR on that edge. RDY_RX=0; ERR_RX=1; ERR_IDX = lowest dropped index.
- ERR: outputs frozen; exits only through PU_RX=0 (then IDLE). Re-arm needs PU_RX low for at least one sampled edge.
- BUSY = (state==SETTLE) or (state==CAL).
- SEQ_MODE changes outside IDLE are ignored.
- N_BLK=1: both modes behave identically.

Test Plan:
Bench parameters for all scenarios: N_BLK=3, SETTLE_CYC=4, TMO_CYC=16.
- Parallel nominal: PU_RX rises, sampled at edge t0.
  - PU_BLK=3'b111 at t0; CAL_BLK=3'b111 at t0+4.
  - RDY_BLK bits rise at t0+6, t0+8, t0+9; CAL bits fall on those edges.
  - RDY_RX=1 at t0+9, BUSY=0.
- Sequential nominal: each block returns RDY 2 cycles after its CAL.
  - PU_BLK goes 001 at t0, 011 at t0+6, 111 at t0+12.
  - CAL is one-hot in sequence.
  - RDY_RX=1 at t0+18.
- Timeout, parallel: block 1 never ready, blocks 0 and 2 ready at t0+6.
  - ERR_RX=1, ERR_IDX=1 at t0+4+15; CAL_BLK=0; PU_BLK=111; RDY_RX=0.
- Ready-loss: after DONE, drop RDY_BLK[2] for one cycle.
  - On the next edge RDY_RX=0, ERR_RX=1, ERR_IDX=2.
  - Error persists after RDY_BLK[2] returns.
- Abort and reset:
  - PU_RX low during sequential CAL of block 1: all outputs 0 on the next edge; state IDLE.
  - Separately, RST_N pulsed low between edges: outputs clear immediately, without waiting for an edge.
- Priority: PU_RX falls in the same cycle that the last RDY arrives -> IDLE, RDY_RX stays 0.
